// File: rtl/mdu_iter_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op and FSM state encodings.
package mdu_iter_pkg;

    typedef enum logic [1:0] {
        MDU_MULTU = 2'b00,
        MDU_MULT  = 2'b01,
        MDU_DIVU  = 2'b10,
        MDU_DIV   = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10
    } mdu_state_e;

    function automatic logic op_is_div(input mdu_op_e op);
        return (op == MDU_DIVU) || (op == MDU_DIV);
    endfunction

    function automatic logic op_is_signed(input mdu_op_e op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// Bus between the CPU control path and the multiply/divide unit:
// operation request, MTHI/MTLO writes, and the HI/LO results.
interface mdu_iter_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mdu_step.sv
// One iteration of the multiply/divide datapath: a shift-add step for multiply,
// a restoring shift-subtract step for divide. Purely combinational.
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] mq,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] acc_nxt,
    output logic [WIDTH-1:0] mq_nxt
);
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;
    logic             unused_diff_bit;

    always_comb begin
        sum             = {1'b0, acc} + (mq[0] ? {1'b0, opnd} : '0);
        shifted         = {acc, mq[WIDTH-1]};
        diff            = {1'b0, shifted} - {2'b00, opnd};
        // The partial remainder always fits in WIDTH bits, so this bit is zero whenever it is kept.
        unused_diff_bit = diff[WIDTH];
        if (is_div) begin
            acc_nxt = diff[WIDTH+1] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
            mq_nxt  = {mq[WIDTH-2:0], ~diff[WIDTH+1]};
        end else begin
            acc_nxt = sum[WIDTH:1];
            mq_nxt  = {sum[0], mq[WIDTH-1:1]};
        end
    end
endmodule

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit writing HI/LO, plus MTHI/MTLO register writes.
// Define MDU_SIGNED_EN to enable signed MULT/DIV; without it every op runs unsigned.
module mdu_iter
    import mdu_iter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic      clk,
    input  logic      rst,
    mdu_iter_if.slave bus
);
    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mq_q, mq_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             is_div_q, is_div_d;
    logic             neg_lo_q, neg_lo_d;
    logic             neg_hi_q, neg_hi_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] step_acc, step_mq;
    logic [WIDTH-1:0] fix_hi, fix_lo;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic             sgn_op;
    mdu_op_e          op_in;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic s);
        return (s && x[WIDTH-1]) ? -x : x;
    endfunction

    assign op_in = mdu_op_e'(bus.op);
`ifdef MDU_SIGNED_EN
    assign sgn_op = op_is_signed(op_in);
`else
    assign sgn_op = 1'b0;
`endif
    assign mag_a = magnitude(bus.a, sgn_op);
    assign mag_b = magnitude(bus.b, sgn_op);

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (is_div_q),
        .acc     (acc_q),
        .mq      (mq_q),
        .opnd    (opnd_q),
        .acc_nxt (step_acc),
        .mq_nxt  (step_mq)
    );

`ifdef MDU_SIGNED_EN
    logic [2*WIDTH-1:0] prod_fix;

    // Product is negated as a whole; quotient and remainder carry independent signs.
    always_comb begin
        prod_fix = neg_lo_q ? -{acc_q, mq_q} : {acc_q, mq_q};
        if (is_div_q) begin
            fix_hi = neg_hi_q ? -acc_q : acc_q;
            fix_lo = neg_lo_q ? -mq_q : mq_q;
        end else begin
            fix_hi = prod_fix[2*WIDTH-1:WIDTH];
            fix_lo = prod_fix[WIDTH-1:0];
        end
    end
`else
    logic unused_sign;
    assign unused_sign = neg_lo_q | neg_hi_q;
    assign fix_hi      = acc_q;
    assign fix_lo      = mq_q;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mq_d     = mq_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d  = S_RUN;
                    cnt_d    = CNT_W'(WIDTH);
                    acc_d    = '0;
                    is_div_d = op_is_div(op_in);
                    // Divide shifts the dividend out of mq; multiply shifts the multiplier.
                    mq_d     = is_div_d ? mag_a : mag_b;
                    opnd_d   = is_div_d ? mag_b : mag_a;
                    neg_lo_d = sgn_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    neg_hi_d = sgn_op & bus.a[WIDTH-1];
                end else begin
                    if (bus.hi_we) hi_d = bus.wdata;
                    if (bus.lo_we) lo_d = bus.wdata;
                end
            end
            S_RUN: begin
                acc_d = step_acc;
                mq_d  = step_mq;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = S_FIX;
            end
            S_FIX: begin
                hi_d    = fix_hi;
                lo_d    = fix_lo;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mq_q     <= '0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mq_q     <= mq_d;
            opnd_q   <= opnd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy = (state_q != S_IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: directed ops push expected HI/LO, a monitor
// pops and compares on every done pulse.
module tb_mdu_iter;
    import mdu_iter_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   total    = 0;
    int   bad      = 0;
    int   done_cnt = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    mdu_iter_if #(.WIDTH(32)) bus ();

    mdu_iter #(.WIDTH(32), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 want no pending op");
            end else begin
                mon_e = exp_q.pop_front();
                check({mon_e.name, "_hi"}, bus.hi, mon_e.hi);
                check({mon_e.name, "_lo"}, bus.lo, mon_e.lo);
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic push, input logic [31:0] ehi, input logic [31:0] elo,
                         input string name);
        exp_t e;
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        if (push) begin
            e.hi   = ehi;
            e.lo   = elo;
            e.name = name;
            exp_q.push_back(e);
        end
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name, output int edges, output int nbusy);
        logic got = 1'b0;
        edges = 1;
        nbusy = 0;
        for (int i = 0; i < 64 && !got; i++) begin
            if (bus.done) got = 1'b1;
            else begin
                if (bus.busy) nbusy++;
                @(negedge clk);
                edges++;
            end
        end
        check({name, "_done_seen"}, 32'(got), 32'd1);
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input string name);
        int edges, nbusy;
        issue(op, a, b, 1'b1, ehi, elo, name);
        wait_done(name, edges, nbusy);
        check({name, "_edges"}, 32'(edges), 32'd34);
        check({name, "_busy_cycles"}, 32'(nbusy), 32'd33);
        @(negedge clk);
        check({name, "_done_width"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int edges, nbusy, d0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
        run_op(MDU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, "divu_100_7");

        // divide by zero, then a new start in the very cycle done is high
        issue(MDU_DIVU, 32'd5, 32'd0, 1'b1, 32'd5, 32'hFFFF_FFFF, "divu_by0");
        wait_done("divu_by0", edges, nbusy);
        issue(MDU_MULTU, 32'd3, 32'd4, 1'b1, 32'd0, 32'd12, "b2b_multu");
        wait_done("b2b_multu", edges, nbusy);
        check("b2b_busy_cycles", 32'(nbusy), 32'd33);
        @(negedge clk);

`ifdef MDU_SIGNED_EN
        run_op(MDU_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_m3_5");
        run_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7_2");
        run_op(MDU_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, "div_7_m2");
        run_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, "div_min_m1");
`else
        run_op(MDU_MULT, 32'hFFFF_FFFD, 32'd5, 32'd4, 32'hFFFF_FFF1, "mult_m3_5");
        run_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 32'd1, 32'h7FFF_FFFC, "div_m7_2");
        run_op(MDU_DIV, 32'd7, 32'hFFFF_FFFE, 32'd7, 32'd0, "div_7_m2");
        run_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, "div_min_m1");
`endif

        // second start and operand changes mid-run must not disturb the first op
        d0 = done_cnt;
        issue(MDU_MULTU, 32'd6, 32'd7, 1'b1, 32'd0, 32'd42, "ignored_start");
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        bus.op    = MDU_DIVU;
        bus.a     = 32'd99;
        bus.b     = 32'd9;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = 32'h0000_1234;
        bus.b     = 32'h0000_0055;
        wait_done("ignored_start", edges, nbusy);
        repeat (40) @(negedge clk);
        check("ignored_start_done_pulses", 32'(done_cnt - d0), 32'd1);

        // MTHI / MTLO in IDLE
        bus.hi_we = 1'b1;
        bus.wdata = 32'h1234_5678;
        @(negedge clk);
        bus.hi_we = 1'b0;
        check("mthi_hi", bus.hi, 32'h1234_5678);
        check("mthi_lo_kept", bus.lo, 32'd42);
        bus.lo_we = 1'b1;
        bus.wdata = 32'hCAFE_F00D;
        @(negedge clk);
        bus.lo_we = 1'b0;
        check("mtlo_lo", bus.lo, 32'hCAFE_F00D);
        check("mtlo_hi_kept", bus.hi, 32'h1234_5678);
        bus.hi_we = 1'b1;
        bus.lo_we = 1'b1;
        bus.wdata = 32'hA5A5_A5A5;
        @(negedge clk);
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        check("mthilo_hi", bus.hi, 32'hA5A5_A5A5);
        check("mthilo_lo", bus.lo, 32'hA5A5_A5A5);

        // writes while busy are ignored
        issue(MDU_MULTU, 32'd2, 32'd3, 1'b1, 32'd0, 32'd6, "we_busy");
        bus.hi_we = 1'b1;
        bus.lo_we = 1'b1;
        bus.wdata = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk);
        check("we_busy_hi", bus.hi, 32'hA5A5_A5A5);
        check("we_busy_lo", bus.lo, 32'hA5A5_A5A5);
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        wait_done("we_busy", edges, nbusy);
        @(negedge clk);

        // hi_we together with start: start wins, write dropped
        bus.hi_we = 1'b1;
        bus.wdata = 32'h5555_5555;
        @(negedge clk);
        check("mthi_pre", bus.hi, 32'h5555_5555);
        bus.wdata = 32'h1111_1111;
        issue(MDU_MULTU, 32'd7, 32'd8, 1'b1, 32'd0, 32'd56, "we_with_start");
        bus.hi_we = 1'b0;
        check("we_with_start_hi", bus.hi, 32'h5555_5555);
        check("we_with_start_busy", 32'(bus.busy), 32'd1);
        wait_done("we_with_start", edges, nbusy);
        @(negedge clk);

        // asynchronous reset in the middle of RUN aborts the op
        issue(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'd0, "aborted");
        repeat (9) @(negedge clk);
        check("abort_busy_before", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_hi", bus.hi, 32'd0);
        check("abort_lo", bus.lo, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(MDU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, "after_abort");

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
